act_row_buf: RTL and testbench

ACT_ROW_BUF -- requirements
Module: act_row_buf

---
 rtl/act_row_buf.sv | 202 ++++++++++++++++++++
 tb/tb_act_row_buf.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_row_buf.sv
// Row buffer: streams one row of activation beats through, then replays it from local storage.
// Optional stall counter is built only when ACT_ROW_BUF_STALL_CNT_EN is defined.
module act_row_buf #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 32,
  parameter int ITER_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_vld,
  input  logic [$clog2(DEPTH):0] cfg_row_len,
  input  logic [ITER_W-1:0]      cfg_row_iter,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_vld,
  output logic                   in_rdy,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   finish_row,
  output logic                   busy,
  output logic [31:0]            stall_cnt
);

  localparam int LEN_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_REPLAY} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [LEN_W-1:0]    r_len;
  logic [ITER_W-1:0]   r_iter;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [ITER_W-1:0]   r_iter_cnt;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_vld;
  logic                r_finish;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_free;
  logic                w_accept;
  logic                w_fill_last;
  logic                w_rd_last;
  logic                w_iter_last;
  logic                w_replay_load;
  logic                w_cfg_ld;
  logic                w_start_ok;
  logic [LEN_W-1:0]    w_cfg_len_eff;
  logic [ITER_W-1:0]   w_cfg_iter_eff;

  assign w_free        = !r_out_vld || out_rdy;
  assign w_accept      = (r_state == S_FILL) && in_vld && w_free;
  assign w_fill_last   = (LEN_W'(r_wr_ptr) == (r_len - LEN_W'(1)));
  assign w_rd_last     = (LEN_W'(r_rd_ptr) == (r_len - LEN_W'(1)));
  assign w_iter_last   = (r_iter_cnt == (r_iter - ITER_W'(1)));
  assign w_replay_load = (r_state == S_REPLAY) && w_free;
  assign w_cfg_ld      = (r_state == S_IDLE) && cfg_vld;
  assign w_start_ok    = (r_state == S_IDLE) && start && !abort;

  always_comb begin
    w_cfg_len_eff  = cfg_row_len;
    w_cfg_iter_eff = cfg_row_iter;
    if (cfg_row_len == '0) begin
      w_cfg_len_eff = LEN_W'(1);
    end else if (cfg_row_len > LEN_W'(DEPTH)) begin
      w_cfg_len_eff = LEN_W'(DEPTH);
    end
    if (cfg_row_iter == '0) begin
      w_cfg_iter_eff = ITER_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FILL;
      S_FILL:   if (w_accept && w_fill_last && (r_iter != ITER_W'(1))) w_state_nxt = S_REPLAY;
      S_REPLAY: if (w_replay_load && w_rd_last && w_iter_last) w_state_nxt = S_FILL;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Config loads alongside a same-cycle start, so the new row uses it immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len  <= LEN_W'(1);
      r_iter <= ITER_W'(1);
    end else if (w_cfg_ld) begin
      r_len  <= w_cfg_len_eff;
      r_iter <= w_cfg_iter_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_iter_cnt <= '0;
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
      r_finish   <= 1'b0;
    end else if (abort) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_iter_cnt <= '0;
      r_out_vld  <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_out_vld <= 1'b0;
          if (start) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_iter_cnt <= '0;
          end
        end
        S_FILL: begin
          if (w_accept) begin
            r_out_data <= in_data;
            r_out_vld  <= 1'b1;
            if (w_fill_last) begin
              r_wr_ptr <= '0;
              if (r_iter == ITER_W'(1)) begin
                r_finish <= 1'b1;
              end else begin
                r_iter_cnt <= ITER_W'(1);
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
          end else if (w_free) begin
            r_out_vld <= 1'b0;
          end
        end
        S_REPLAY: begin
          // The fill pass counts as iteration 0, so replay begins at iter_cnt 1.
          if (w_free) begin
            r_out_data <= r_mem[r_rd_ptr];
            r_out_vld  <= 1'b1;
            if (w_rd_last) begin
              r_rd_ptr <= '0;
              if (w_iter_last) begin
                r_finish   <= 1'b1;
                r_iter_cnt <= '0;
              end else begin
                r_iter_cnt <= r_iter_cnt + ITER_W'(1);
              end
            end else begin
              r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
          end
        end
        default: r_out_vld <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

`ifdef ACT_ROW_BUF_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_stall_cnt <= '0;
    end else if (r_out_vld && !out_rdy && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

  assign in_rdy     = (r_state == S_FILL) && w_free;
  assign out_data   = r_out_data;
  assign out_vld    = r_out_vld;
  assign finish_row = r_finish;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_act_row_buf.sv
// Scoreboard bench for act_row_buf: stimulus queues expected beats, a negedge monitor checks them.
module tb_act_row_buf;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam int ITER_W = 10;
  localparam int LEN_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              fin;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_vld;
  logic [LEN_W-1:0]  cfg_row_len;
  logic [ITER_W-1:0] cfg_row_iter;
  logic              start;
  logic              abort;
  logic [DATA_W-1:0] in_data;
  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] out_data;
  logic              out_vld;
  logic              out_rdy = 1'b1;
  logic              finish_row;
  logic              busy;
  logic [31:0]       stall_cnt;

  exp_t              sbQ[$];
  exp_t              monExp;
  int                nChecks = 0;
  int                nFails = 0;
  int                tbStallCycles = 0;
  bit                toggleMode = 1'b0;
  logic              prevVld = 1'b0;
  logic              prevRdy = 1'b1;
  logic [DATA_W-1:0] prevData = '0;

  act_row_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .cfg_vld(cfg_vld), .cfg_row_len(cfg_row_len),
    .cfg_row_iter(cfg_row_iter), .start(start), .abort(abort),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .finish_row(finish_row), .busy(busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushExp(input logic [DATA_W-1:0] d, input logic f);
    sbQ.push_back('{fin: f, data: d});
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] d);
    bit accepted = 1'b0;
    in_vld  = 1'b1;
    in_data = d;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      accepted = (in_rdy === 1'b1);
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    checkOutput("beat_accepted", 64'(accepted), 64'd1);
    if (accepted) begin
      checkOutput("latency_vld", 64'(out_vld), 64'd1);
      checkOutput("latency_data", 64'(out_data), 64'(d));
    end
  endtask

  task automatic startRow(input int len, input int iter);
    cfg_vld       = 1'b1;
    cfg_row_len   = LEN_W'(len);
    cfg_row_iter  = ITER_W'(iter);
    start         = 1'b1;
    tbStallCycles = 0;
    @(posedge clk);
    #1;
    cfg_vld = 1'b0;
    start   = 1'b0;
  endtask

  task automatic doAbort();
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 400 && sbQ.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("scoreboard_drain", 64'(sbQ.size()), 64'd0);
  endtask

  // Back-pressure source: steady ready, or alternating ready while toggleMode is set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_rdy = toggleMode ? ~out_rdy : 1'b1;
    end
  end

  // A beat is new unless the previous cycle held it under back-pressure.
  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      if (prevVld && !prevRdy) begin
        checkOutput("stall_hold_data", 64'(out_data), 64'(prevData));
        if (finish_row !== 1'b0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL finish_on_hold: got finish_row=%b, expected 0 at %0t", finish_row, $time);
        end
      end else if (sbQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_beat: got data 0x%0h, expected no beat at %0t", out_data, $time);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("beat_data", 64'(out_data), 64'(monExp.data));
        checkOutput("beat_finish", 64'(finish_row), 64'(monExp.fin));
      end
    end else if (finish_row === 1'b1) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL finish_without_vld: got finish_row=1, expected 0 at %0t", $time);
    end
    if (out_vld === 1'b1 && out_rdy === 1'b0) tbStallCycles++;
    prevVld  = (out_vld === 1'b1);
    prevRdy  = out_rdy;
    prevData = out_data;
  end

  initial begin
    #1000000;
    nFails++;
    $display("[TB] FAIL watchdog: got no completion, expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    rst = 1'b1; cfg_vld = 1'b0; start = 1'b0; abort = 1'b0;
    in_vld = 1'b0; in_data = '0; cfg_row_len = '0; cfg_row_iter = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_vld", 64'(out_vld), 64'd0);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_in_rdy", 64'(in_rdy), 64'd0);
    checkOutput("rst_finish", 64'(finish_row), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] len=4 iter=1, 8 streamed beats, cfg_vld while filling");
    startRow(4, 1);
    checkOutput("busy_in_fill", 64'(busy), 64'd1);
    cfg_vld = 1'b1; cfg_row_len = LEN_W'(2); cfg_row_iter = ITER_W'(3);
    @(posedge clk);
    #1;
    cfg_vld = 1'b0;
    for (int i = 0; i < 8; i++) pushExp(DATA_W'(16'h0100 + i), (i % 4) == 3);
    for (int i = 0; i < 8; i++) applyStimulus(DATA_W'(16'h0100 + i));
    waitDrain();
    doAbort();
    checkOutput("abort_to_idle", 64'(busy), 64'd0);

    $display("[TB] abort has priority over start");
    abort = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0; start = 1'b0;
    checkOutput("abort_over_start", 64'(busy), 64'd0);

    $display("[TB] len=4 iter=3 replay");
    startRow(4, 3);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) pushExp(DATA_W'(16'h00A0 + i), (r == 2) && (i == 3));
    for (int i = 0; i < 4; i++) applyStimulus(DATA_W'(16'h00A0 + i));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("replay_in_rdy", 64'(in_rdy), 64'd0);
      @(posedge clk);
    end
    waitDrain();
    doAbort();

    $display("[TB] len=3 iter=2 with toggling out_rdy");
    toggleMode = 1'b1;
    startRow(3, 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++) pushExp(DATA_W'(16'h0030 + i), (r == 1) && (i == 2));
    for (int i = 0; i < 3; i++) applyStimulus(DATA_W'(16'h0030 + i));
    waitDrain();
    toggleMode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef ACT_ROW_BUF_STALL_CNT_EN
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(tbStallCycles));
`else
    checkOutput("stall_cnt_tied", 64'(stall_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    doAbort();

    $display("[TB] cfg_row_len=40 clamps to DEPTH, iter=2");
    startRow(40, 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < DEPTH; i++) pushExp(DATA_W'(16'h0200 + i), (r == 1) && (i == DEPTH - 1));
    for (int i = 0; i < DEPTH; i++) applyStimulus(DATA_W'(16'h0200 + i));
    @(negedge clk);
    checkOutput("deep_replay_in_rdy", 64'(in_rdy), 64'd0);
    waitDrain();
    doAbort();

    $display("[TB] abort during replay beat 2, then refill");
    startRow(4, 2);
    for (int i = 0; i < 4; i++) pushExp(DATA_W'(16'h00C0 + i), 1'b0);
    pushExp(DATA_W'(16'h00C0), 1'b0);
    pushExp(DATA_W'(16'h00C1), 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(DATA_W'(16'h00C0 + i));
    @(posedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort_out_vld", 64'(out_vld), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_finish", 64'(finish_row), 64'd0);
    checkOutput("abort_flush", 64'(sbQ.size()), 64'd0);
    startRow(4, 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) pushExp(DATA_W'(16'h00D0 + i), (r == 1) && (i == 3));
    for (int i = 0; i < 4; i++) applyStimulus(DATA_W'(16'h00D0 + i));
    waitDrain();
    doAbort();

    $display("[TB] reset mid-fill, then reconfigure");
    startRow(4, 1);
    pushExp(DATA_W'(16'h00E0), 1'b0);
    pushExp(DATA_W'(16'h00E1), 1'b0);
    applyStimulus(DATA_W'(16'h00E0));
    applyStimulus(DATA_W'(16'h00E1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_out_vld", 64'(out_vld), 64'd0);
    checkOutput("midrst_out_data", 64'(out_data), 64'd0);
    checkOutput("midrst_in_rdy", 64'(in_rdy), 64'd0);
    checkOutput("midrst_finish", 64'(finish_row), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    startRow(2, 2);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 2; i++) pushExp(DATA_W'(16'h00F0 + i), (r == 1) && (i == 1));
    applyStimulus(DATA_W'(16'h00F0));
    applyStimulus(DATA_W'(16'h00F1));
    @(negedge clk);
    checkOutput("post_rst_replay_in_rdy", 64'(in_rdy), 64'd0);
    waitDrain();
    doAbort();

    $display("[TB] zero length and zero iterations clamp to 1");
    startRow(0, 0);
    pushExp(DATA_W'(16'h0055), 1'b1);
    applyStimulus(DATA_W'(16'h0055));
    waitDrain();
    checkOutput("clamp_stays_fill", 64'(busy), 64'd1);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
